// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
// Pure declarations: no logic, latency or flow control of its own.
package wb_arb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// One Wishbone channel (request + response) seen from either end of the link.
// Wires only: latency and stall behaviour belong to whoever drives it.
interface wb_arb_if;

    logic                          cyc;
    logic                          stb;
    logic                          we;
    logic [wb_arb_pkg::WB_SEL_W-1:0] sel;
    logic [wb_arb_pkg::WB_ADR_W-1:0] adr;
    logic [wb_arb_pkg::WB_DAT_W-1:0] dat_w;
    logic [wb_arb_pkg::WB_DAT_W-1:0] dat_r;
    logic                          ack;
    logic                          err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts enabled cycles, pulses expire_o on the limit-th one.
// Expire is combinational from the registered count; clear wins over counting.
module wb_arb_watchdog (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cnt_en_i,
    input  logic        clr_i,
    input  logic [15:0] limit_i,
    output logic        expire_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // cnt_q holds stalls already seen, so this cycle is the limit-th when it equals limit-1
    assign expire_o = cnt_en_i & ~clr_i & (cnt_q == (limit_i - 16'd1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = 16'd0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter with bus lock, alternating tie-break and stall watchdog.
// Grant takes one cycle after cyc; data path is combinational while owned; slave stalls abort after TIMEOUT_CYCLES.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,

    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,

    output logic [1:0]          grant_o,
    output logic [15:0]         to_count_o
);

    arb_state_e  state_q;
    owner_t      last_q;
    logic [1:0]  grant_q;
    logic [15:0] to_count_q;

    logic        own0;
    logic        own1;
    logic        wd_en;
    logic        wd_expire;

    assign own0 = (state_q == ST_OWN0);
    assign own1 = (state_q == ST_OWN1);

    // A stall is an owned cycle with a strobe out and no response back
    assign wd_en = ((own0 & m0_stb_i) | (own1 & m1_stb_i)) & ~s_ack_i & ~s_err_i;

    wb_arb_watchdog u_watchdog (
        .clk_i    (wb_clk_i),
        .rst_n_i  (wb_rst_n_i),
        .cnt_en_i (wd_en),
        .clr_i    (~wd_en),
        .limit_i  (TIMEOUT_CYCLES),
        .expire_o (wd_expire)
    );

    assign grant_o    = grant_q;
    assign to_count_o = to_count_q;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                m0_err_o = s_err_i & m0_stb_i;
            end
            ST_OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                m1_err_o = s_err_i & m1_stb_i;
            end
            // Late slave responses are swallowed here; only the abort error escapes
            ST_ABORT: begin
                if (last_q == OWNER_M0) begin
                    m0_err_o = 1'b1;
                end else begin
                    m1_err_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            last_q     <= OWNER_M1;
            grant_q    <= 2'b00;
            to_count_q <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (last_q == OWNER_M1) begin
                            state_q <= ST_OWN0;
                            grant_q <= 2'b01;
                        end else begin
                            state_q <= ST_OWN1;
                            grant_q <= 2'b10;
                        end
                    end else if (m0_cyc_i) begin
                        state_q <= ST_OWN0;
                        grant_q <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_q <= ST_OWN1;
                        grant_q <= 2'b10;
                    end
                end
                ST_OWN0: begin
                    if (!m0_cyc_i) begin
                        state_q <= ST_IDLE;
                        last_q  <= OWNER_M0;
                        grant_q <= 2'b00;
                    end else if (wd_expire) begin
                        state_q <= ST_ABORT;
                        last_q  <= OWNER_M0;
                        grant_q <= 2'b00;
                        if (to_count_q != 16'hFFFF) begin
                            to_count_q <= to_count_q + 16'd1;
                        end
                    end
                end
                ST_OWN1: begin
                    if (!m1_cyc_i) begin
                        state_q <= ST_IDLE;
                        last_q  <= OWNER_M1;
                        grant_q <= 2'b00;
                    end else if (wd_expire) begin
                        state_q <= ST_ABORT;
                        last_q  <= OWNER_M1;
                        grant_q <= 2'b00;
                        if (to_count_q != 16'hFFFF) begin
                            to_count_q <= to_count_q + 16'd1;
                        end
                    end
                end
                ST_ABORT: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios then random traffic against a cycle model.
module tb_wb_arbiter_2m;

    localparam int TO = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic [1:0]  grant_o;
    logic [15:0] to_count_o;

    wb_arb_if m0_if ();
    wb_arb_if m1_if ();
    wb_arb_if s_if ();

    always #5 wb_clk_i = ~wb_clk_i;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(16'(TO))) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .m0_cyc_i   (m0_if.cyc),
        .m0_stb_i   (m0_if.stb),
        .m0_we_i    (m0_if.we),
        .m0_sel_i   (m0_if.sel),
        .m0_adr_i   (m0_if.adr),
        .m0_dat_i   (m0_if.dat_w),
        .m0_dat_o   (m0_if.dat_r),
        .m0_ack_o   (m0_if.ack),
        .m0_err_o   (m0_if.err),
        .m1_cyc_i   (m1_if.cyc),
        .m1_stb_i   (m1_if.stb),
        .m1_we_i    (m1_if.we),
        .m1_sel_i   (m1_if.sel),
        .m1_adr_i   (m1_if.adr),
        .m1_dat_i   (m1_if.dat_w),
        .m1_dat_o   (m1_if.dat_r),
        .m1_ack_o   (m1_if.ack),
        .m1_err_o   (m1_if.err),
        .s_cyc_o    (s_if.cyc),
        .s_stb_o    (s_if.stb),
        .s_we_o     (s_if.we),
        .s_sel_o    (s_if.sel),
        .s_adr_o    (s_if.adr),
        .s_dat_o    (s_if.dat_w),
        .s_dat_i    (s_if.dat_r),
        .s_ack_i    (s_if.ack),
        .s_err_i    (s_if.err),
        .grant_o    (grant_o),
        .to_count_o (to_count_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the bus (-1 = nobody), pending abort, tie-break memory
    int m_owner;
    int m_abort;
    int m_abort_who;
    int m_last;
    int m_stall;
    int m_tocnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_abort     = 0;
        m_abort_who = 0;
        m_last      = 1;
        m_stall     = 0;
        m_tocnt     = 0;
    endtask

    task automatic chk_all();
        logic [1:0]  eg;
        logic [70:0] es;
        logic [33:0] e0;
        logic [33:0] e1;
        eg = '0; es = '0; e0 = '0; e1 = '0;
        if (m_owner == 0) begin
            eg = 2'b01;
            es = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.sel, m0_if.adr, m0_if.dat_w};
            e0 = {s_if.dat_r, s_if.ack & m0_if.stb, s_if.err & m0_if.stb};
        end else if (m_owner == 1) begin
            eg = 2'b10;
            es = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.sel, m1_if.adr, m1_if.dat_w};
            e1 = {s_if.dat_r, s_if.ack & m1_if.stb, s_if.err & m1_if.stb};
        end
        if (m_abort != 0) begin
            if (m_abort_who == 0) e0 = 34'd1;
            else                  e1 = 34'd1;
        end
        chk("grant", grant_o, eg);
        chk("s_req", {s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.adr, s_if.dat_w}, es);
        chk("m0_rsp", {m0_if.dat_r, m0_if.ack, m0_if.err}, e0);
        chk("m1_rsp", {m1_if.dat_r, m1_if.ack, m1_if.err}, e1);
        chk("to_count", to_count_o, 128'(m_tocnt));
    endtask

    task automatic model_update();
        logic cyc;
        logic stb;
        if (m_abort != 0) begin
            m_abort = 0;
        end else if (m_owner < 0) begin
            if (m0_if.cyc && m1_if.cyc) m_owner = 1 - m_last;
            else if (m0_if.cyc)         m_owner = 0;
            else if (m1_if.cyc)         m_owner = 1;
        end else begin
            cyc = (m_owner == 0) ? m0_if.cyc : m1_if.cyc;
            stb = (m_owner == 0) ? m0_if.stb : m1_if.stb;
            if (!cyc) begin
                m_last  = m_owner;
                m_owner = -1;
                m_stall = 0;
            end else if (stb && !s_if.ack && !s_if.err) begin
                m_stall++;
                if (m_stall == TO) begin
                    m_abort     = 1;
                    m_abort_who = m_owner;
                    m_last      = m_owner;
                    m_owner     = -1;
                    m_stall     = 0;
                    if (m_tocnt < 65535) m_tocnt++;
                end
            end else begin
                m_stall = 0;
            end
        end
    endtask

    // Called at a falling edge: check, advance model, return just after the rising edge
    task automatic tick_n();
        chk_all();
        model_update();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic tick();
        @(negedge wb_clk_i);
        tick_n();
    endtask

    task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        if (n == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.sel = sel; m0_if.adr = adr; m0_if.dat_w = dat;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.sel = sel; m1_if.adr = adr; m1_if.dat_w = dat;
        end
    endtask

    task automatic set_s(input logic ack, input logic err, input logic [31:0] dat);
        s_if.ack = ack; s_if.err = err; s_if.dat_r = dat;
    endtask

    task automatic clear_all();
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 0, 32'h0);
    endtask

    // Entered just after a rising edge; reset is asserted and released away from edges
    task automatic do_reset();
        #2;
        wb_rst_n_i = 1'b0;
        model_reset();
        #1;
        chk_all();
        chk("rst_to_count", to_count_o, 128'd0);
        chk("rst_grant", grant_o, 128'd0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b1;
    endtask

    initial begin
        wb_rst_n_i = 1'b0;
        clear_all();
        model_reset();
        @(posedge wb_clk_i);
        #1;
        do_reset();

        // Single read of 0x10 by m0, slave acks one cycle after it sees stb
        set_m(0, 1, 1, 0, 4'hF, 32'h10, 32'h0);
        @(negedge wb_clk_i);
        chk("r030_grant_idle", grant_o, 128'd0);
        tick_n();
        @(negedge wb_clk_i);
        chk("r030_grant", grant_o, 128'h1);
        chk("r030_s_adr", s_if.adr, 128'h10);
        tick_n();
        set_s(1, 0, 32'hCAFE_0010);
        @(negedge wb_clk_i);
        chk("r030_m0_ack", {m0_if.ack, m0_if.dat_r}, {1'b1, 32'hCAFE_0010});
        chk("r030_m1_quiet", {m1_if.dat_r, m1_if.ack, m1_if.err}, 128'd0);
        tick_n();
        clear_all();
        tick();
        tick();

        // Simultaneous requests, twice: m0 first, then m1 after an idle cycle
        do_reset();
        set_m(0, 1, 1, 0, 4'hF, 32'h100, 32'h0);
        set_m(1, 1, 1, 1, 4'h3, 32'h200, 32'h11);
        tick();
        set_s(1, 0, 32'h5A5A_0001);
        @(negedge wb_clk_i);
        chk("r031_first", grant_o, 128'h1);
        chk("r031_m1_wait", m1_if.ack, 128'd0);
        tick_n();
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 0, 32'h0);
        tick();
        set_m(0, 1, 1, 0, 4'hF, 32'h104, 32'h0);
        @(negedge wb_clk_i);
        chk("r031_gap", grant_o, 128'd0);
        tick_n();
        set_s(1, 0, 32'h5A5A_0002);
        @(negedge wb_clk_i);
        chk("r031_second", grant_o, 128'h2);
        chk("r031_m1_ack", {m1_if.ack, m0_if.ack}, 128'h2);
        tick_n();
        set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 0, 32'h0);
        tick();
        tick();
        @(negedge wb_clk_i);
        chk("r031_third", grant_o, 128'h1);
        tick_n();
        clear_all();
        tick();
        tick();

        // Bus lock: m1 writes three beats while m0 waits
        set_m(1, 1, 1, 1, 4'hF, 32'h300, 32'hB0);
        tick();
        set_m(0, 1, 1, 0, 4'hF, 32'h400, 32'h0);
        for (int b = 0; b < 3; b++) begin
            set_m(1, 1, 1, 1, 4'hF, 32'h300 + 32'(4 * b), 32'hB0 + 32'(b));
            set_s(1, 0, 32'h0);
            @(negedge wb_clk_i);
            chk("r032_beat", {grant_o, s_if.we, s_if.adr, s_if.dat_w},
                {2'b10, 1'b1, 32'h300 + 32'(4 * b), 32'hB0 + 32'(b)});
            tick_n();
        end
        set_m(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_s(0, 0, 32'h0);
        tick();
        tick();
        @(negedge wb_clk_i);
        chk("r032_m0_after", grant_o, 128'h1);
        tick_n();
        clear_all();
        tick();
        tick();

        // Watchdog: slave never answers m0, m1 pending during the stall
        set_m(0, 1, 1, 1, 4'hF, 32'h500, 32'h77);
        tick();
        set_m(1, 1, 1, 0, 4'hF, 32'h600, 32'h0);
        for (int c = 0; c < TO; c++) begin
            @(negedge wb_clk_i);
            chk("r033_stall", {grant_o, m0_if.err}, {2'b01, 1'b0});
            tick_n();
        end
        @(negedge wb_clk_i);
        chk("r033_abort", {grant_o, s_if.cyc, m0_if.err, m1_if.err}, {2'b00, 1'b0, 1'b1, 1'b0});
        chk("r033_count", to_count_o, 128'd1);
        tick_n();
        @(negedge wb_clk_i);
        chk("r033_err_once", m0_if.err, 128'd0);
        tick_n();
        @(negedge wb_clk_i);
        chk("r033_next_m1", grant_o, 128'h2);
        tick_n();
        clear_all();
        tick();
        tick();

        // Owner drops cyc, slave answers late: nobody sees it
        set_m(0, 1, 1, 0, 4'hF, 32'h700, 32'h0);
        tick();
        tick();
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        set_s(1, 1, 32'hDEAD_BEEF);
        @(negedge wb_clk_i);
        chk("r034_dropped", {grant_o, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 128'd0);
        tick_n();
        clear_all();
        tick();

        // Reset mid-beat with the slave driving a response
        set_m(0, 1, 1, 1, 4'hF, 32'h800, 32'h1234);
        tick();
        set_s(1, 1, 32'hFFFF_0000);
        do_reset();
        clear_all();
        tick();

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            if ($urandom_range(0, 4) == 0) m0_if.cyc = ~m0_if.cyc;
            if ($urandom_range(0, 4) == 0) m1_if.cyc = ~m1_if.cyc;
            m0_if.stb   = m0_if.cyc & ($urandom_range(0, 3) != 0);
            m1_if.stb   = m1_if.cyc & ($urandom_range(0, 3) != 0);
            m0_if.we    = 1'($urandom_range(0, 1));
            m1_if.we    = 1'($urandom_range(0, 1));
            m0_if.sel   = 4'($urandom);
            m1_if.sel   = 4'($urandom);
            m0_if.adr   = $urandom;
            m1_if.adr   = $urandom;
            m0_if.dat_w = $urandom;
            m1_if.dat_w = $urandom;
            s_if.ack    = ($urandom_range(0, 3) == 0);
            s_if.err    = ($urandom_range(0, 15) == 0);
            s_if.dat_r  = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd255, legal range 1..65535: watchdog limit in cycles.
REQ-002 SHALL have port wb_clk_i, in, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_n_i, in, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports mN_cyc_i, mN_stb_i, mN_we_i (N=0,1), in, 1 each: master N Wishbone control.
REQ-005 SHALL have ports mN_sel_i, in, 4; mN_adr_i, in, 32; mN_dat_i, in, 32: master N byte enables, address, write data.
REQ-006 SHALL have ports mN_dat_o, out, 32; mN_ack_o, out, 1; mN_err_o, out, 1: master N read data, ack, error.
REQ-007 SHALL have ports s_cyc_o, s_stb_o, s_we_o, out, 1; s_sel_o, out, 4; s_adr_o, s_dat_o, out, 32: shared slave request.
REQ-008 SHALL have ports s_dat_i, in, 32; s_ack_i, s_err_i, in, 1: shared slave response.
REQ-009 SHALL have port grant_o, out, 2: one-hot current owner, 2'b00 when no owner.
REQ-010 SHALL have port to_count_o, out, 16: count of watchdog aborts.

Function
REQ-011 SHALL implement FSM states IDLE, OWN0, OWN1, ABORT.
REQ-012 IDLE: only m0_cyc_i high -> OWN0; only m1_cyc_i high -> OWN1; both high -> the master not in last_r; neither -> stay IDLE.
REQ-013 Grant SHALL be registered: the slave sees a request no earlier than the cycle after cyc is first sampled high.
REQ-014 In OWNn, all s_* request outputs SHALL combinationally equal master n's inputs.
REQ-015 In IDLE and ABORT, all s_* request outputs SHALL be 0.
REQ-016 Owner's mN_dat_o SHALL equal s_dat_i, and its mN_ack_o SHALL equal s_ack_i & mN_stb_i.
REQ-017 Owner's mN_err_o SHALL be (s_err_i & mN_stb_i) or the ABORT pulse.
REQ-018 Non-owner SHALL see mN_dat_o=0, mN_ack_o=0, mN_err_o=0.
REQ-019 OWNn -> IDLE when mN_cyc_i is sampled low; last_r <= n; at least one IDLE cycle SHALL separate ownerships.
REQ-020 Bus lock: ownership SHALL persist across multiple stb beats while cyc stays high, regardless of the other master's requests.
REQ-021 Watchdog SHALL count, from 0, cycles in OWNn with stb high and no s_ack_i/s_err_i; it SHALL clear on ack, err, stb low or leaving OWNn.
REQ-022 When the watchdog reaches TIMEOUT_CYCLES: next state ABORT; last_r <= owner; to_count_o increments, saturating at 16'hFFFF.
REQ-023 ABORT SHALL last exactly one cycle, assert the aborted owner's mN_err_o, and go to IDLE.
REQ-024 A late s_ack_i/s_err_i arriving in IDLE or ABORT SHALL be dropped and not routed to any master.
REQ-025 Owner dropping cyc mid-transfer SHALL release the bus per REQ-019 without error.

Reset
REQ-026 wb_rst_n_i low SHALL asynchronously force state IDLE, last_r=1 (m0 wins the first tie), watchdog=0, to_count_o=0, grant_o=0, all s_* and mN_* outputs 0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err to either master.

Structure
REQ-028 Package wb_arb_pkg SHALL hold the state enum, owner-index type and WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
REQ-029 Watchdog counter SHALL be sub-module wb_arb_watchdog (inputs: count enable, clear, limit; output: expire pulse).

Verification
REQ-030 Reset release, m0 single read of 0x10 while slave acks one cycle after stb -> grant_o=01 one cycle after cyc; m0_ack_o=1 with slave data; m1 outputs 0.
REQ-031 m0 and m1 cyc rise in the same cycle, twice in a row -> first grant m0, after release and one IDLE cycle grant m1, then m0.
REQ-032 m1 holds cyc for 3 write beats while m0 requests -> all 3 beats reach the slave before grant_o=01.
REQ-033 TIMEOUT_CYCLES=4, slave never acks -> ABORT after 4 stalled cycles; m0_err_o=1 for one cycle; to_count_o=1; next grant goes to m1 if pending.
REQ-034 Owner drops cyc, slave acks one cycle later -> neither master sees ack; state IDLE.
REQ-035 wb_rst_n_i pulsed low mid-beat, off-edge -> outputs 0 immediately and to_count_o=0.
